// File: rtl/oper_swap_cmp_if.sv
// Operand/result handshake bundle for the oper_swap_cmp stage.
// Carries zero_result_o only when OPER_SWAP_ZERO_FLAG_EN is defined.
interface oper_swap_cmp_if #(
    parameter int W = 32
);
    logic         in_valid_i;
    logic         in_ready_o;
    logic         AddSubt_i;
    logic [W-1:0] Data_X_i;
    logic [W-1:0] Data_Y_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] DMP_o;
    logic [W-1:0] DmP_o;
    logic         gtXY_o;
    logic         eqXY_o;
    logic         eff_sub_o;
    logic         sgn_result_o;
`ifdef OPER_SWAP_ZERO_FLAG_EN
    logic         zero_result_o;
`endif

    // Producer of operands / consumer of results.
    modport master (
        output in_valid_i, AddSubt_i, Data_X_i, Data_Y_i, out_ready_i,
        input  in_ready_o, out_valid_o, DMP_o, DmP_o, gtXY_o, eqXY_o,
               eff_sub_o, sgn_result_o
`ifdef OPER_SWAP_ZERO_FLAG_EN
        , input zero_result_o
`endif
    );

    // The compare/swap stage itself.
    modport slave (
        input  in_valid_i, AddSubt_i, Data_X_i, Data_Y_i, out_ready_i,
        output in_ready_o, out_valid_o, DMP_o, DmP_o, gtXY_o, eqXY_o,
               eff_sub_o, sgn_result_o
`ifdef OPER_SWAP_ZERO_FLAG_EN
        , output zero_result_o
`endif
    );
endinterface

// File: rtl/oper_swap_cmp.sv
// Two-stage operand register + magnitude compare/swap front end of the FP add/subtract path.
// Define OPER_SWAP_ZERO_FLAG_EN to add the registered exact-cancellation flag zero_result_o.
module oper_swap_cmp #(
    parameter int W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    oper_swap_cmp_if.slave     bus
);

    // Result sign: X's sign when |X| wins, (sgnY ^ op) when |Y| wins,
    // +0 on exact cancellation, X's sign on an equal-magnitude effective add.
    function automatic logic sign_rule(input logic gt, input logic eq,
                                       input logic sgn_x, input logic sgn_y,
                                       input logic op);
        return (gt | (op ^ sgn_y)) & (sgn_x | ~(eq | gt));
    endfunction

    logic         v1_r;
    logic [W-1:0] x1_r;
    logic [W-1:0] y1_r;
    logic         op1_r;

    logic         v2_r;
    logic [W-1:0] dmp_r;
    logic [W-1:0] dmp_small_r;
    logic         gt_r;
    logic         eq_r;
    logic         eff_sub_r;
    logic         sgn_r;

    logic         s2_adv_s;
    logic         s1_adv_s;
    logic         gt_s;
    logic         eq_s;
    logic         eff_sub_s;
    logic         sgn_s;
    logic         x_wins_s;
    logic [W-1:0] dmp_s;
    logic [W-1:0] dmp_small_s;

    assign s2_adv_s = ~v2_r | bus.out_ready_i;
    assign s1_adv_s = ~v1_r | s2_adv_s;

    // Compare and swap on the S1 operands; sign bit excluded from the magnitude.
    always_comb begin
        gt_s        = (x1_r[W-2:0] > y1_r[W-2:0]);
        eq_s        = (x1_r[W-2:0] == y1_r[W-2:0]);
        eff_sub_s   = x1_r[W-1] ^ y1_r[W-1] ^ op1_r;
        sgn_s       = sign_rule(gt_s, eq_s, x1_r[W-1], y1_r[W-1], op1_r);
        x_wins_s    = gt_s | eq_s;
        dmp_s       = x_wins_s ? x1_r : y1_r;
        dmp_small_s = x_wins_s ? y1_r : x1_r;
    end

    // Stage 1: operand capture on an input handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_r  <= 1'b0;
            x1_r  <= {W{1'b0}};
            y1_r  <= {W{1'b0}};
            op1_r <= 1'b0;
        end else if (s1_adv_s) begin
            v1_r <= bus.in_valid_i;
            if (bus.in_valid_i) begin
                x1_r  <= bus.Data_X_i;
                y1_r  <= bus.Data_Y_i;
                op1_r <= bus.AddSubt_i;
            end
        end
    end

    // Stage 2: output register; data only reloads from a valid S1 entry so a stall holds it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_r        <= 1'b0;
            dmp_r       <= {W{1'b0}};
            dmp_small_r <= {W{1'b0}};
            gt_r        <= 1'b0;
            eq_r        <= 1'b0;
            eff_sub_r   <= 1'b0;
            sgn_r       <= 1'b0;
        end else if (s2_adv_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                dmp_r       <= dmp_s;
                dmp_small_r <= dmp_small_s;
                gt_r        <= gt_s;
                eq_r        <= eq_s;
                eff_sub_r   <= eff_sub_s;
                sgn_r       <= sgn_s;
            end
        end
    end

`ifdef OPER_SWAP_ZERO_FLAG_EN
    logic zero_r;
    logic zero_s;

    // Exact cancellation, or both magnitudes zero (covers 0 +/- 0 in either sense).
    always_comb begin
        zero_s = (eq_s & eff_sub_s) |
                 ((x1_r[W-2:0] == {(W-1){1'b0}}) & (y1_r[W-2:0] == {(W-1){1'b0}}));
    end

    // Zero flag rides alongside the other S2 outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_r <= 1'b0;
        end else if (s2_adv_s && v1_r) begin
            zero_r <= zero_s;
        end
    end

    assign bus.zero_result_o = zero_r;
`endif

    assign bus.in_ready_o   = s1_adv_s;
    assign bus.out_valid_o  = v2_r;
    assign bus.DMP_o        = dmp_r;
    assign bus.DmP_o        = dmp_small_r;
    assign bus.gtXY_o       = gt_r;
    assign bus.eqXY_o       = eq_r;
    assign bus.eff_sub_o    = eff_sub_r;
    assign bus.sgn_result_o = sgn_r;

endmodule

// File: tb/tb_oper_swap_cmp.sv
// Self-checking bench for oper_swap_cmp: directed vector table, backpressure and
// mid-stream reset sequences, then random traffic against a scoreboard model.
module tb_oper_swap_cmp;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] dmp;
        logic [W-1:0] dmp_small;
        logic         gt;
        logic         eq;
        logic         eff;
        logic         sgn;
        logic         zero;
    } res_t;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         op;
        logic [W-1:0] e_dmp;
        logic [W-1:0] e_dmp_small;
        logic         e_gt;
        logic         e_eq;
        logic         e_eff;
        logic         e_sgn;
        logic         e_zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   accepted = 0;
    int   popped = 0;
    res_t q[$];

    oper_swap_cmp_if #(.W(W)) bus ();
    oper_swap_cmp #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference: result from the arithmetic meaning of a signed-magnitude add/sub.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic op);
        res_t r;
        longint unsigned mx, my;
        mx    = longint'(x & {1'b0, {(W-1){1'b1}}});
        my    = longint'(y & {1'b0, {(W-1){1'b1}}});
        r.gt  = (mx > my);
        r.eq  = (mx == my);
        r.eff = (x[W-1] != (y[W-1] ^ op));
        if (mx > my)      r.sgn = x[W-1];
        else if (mx < my) r.sgn = y[W-1] ^ op;
        else if (r.eff)   r.sgn = 1'b0;
        else              r.sgn = x[W-1];
        r.dmp       = (mx >= my) ? x : y;
        r.dmp_small = (mx >= my) ? y : x;
        r.zero      = (r.eq && r.eff) || (mx == 0 && my == 0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_res(input string tag, input res_t e);
        chk({tag, " DMP"}, 64'(bus.DMP_o), 64'(e.dmp));
        chk({tag, " DmP"}, 64'(bus.DmP_o), 64'(e.dmp_small));
        chk({tag, " gtXY"}, 64'(bus.gtXY_o), 64'(e.gt));
        chk({tag, " eqXY"}, 64'(bus.eqXY_o), 64'(e.eq));
        chk({tag, " eff_sub"}, 64'(bus.eff_sub_o), 64'(e.eff));
        chk({tag, " sgn"}, 64'(bus.sgn_result_o), 64'(e.sgn));
`ifdef OPER_SWAP_ZERO_FLAG_EN
        chk({tag, " zero"}, 64'(bus.zero_result_o), 64'(e.zero));
`endif
    endtask

    function automatic res_t snap_out();
        res_t s;
        s.dmp = bus.DMP_o; s.dmp_small = bus.DmP_o; s.gt = bus.gtXY_o; s.eq = bus.eqXY_o;
        s.eff = bus.eff_sub_o; s.sgn = bus.sgn_result_o; s.zero = 1'b0;
`ifdef OPER_SWAP_ZERO_FLAG_EN
        s.zero = bus.zero_result_o;
`endif
        return s;
    endfunction

    // One clock: inputs already driven at a negedge; returns at the next negedge.
    task automatic tick();
        logic stall;
        res_t snap, e;
        #1;
        stall = 1'b0;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (q.size() == 0) begin
                    chk("spurious output", 64'(1), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk_res("scoreboard", e);
                    popped++;
                end
            end
            if (bus.out_valid_o && !bus.out_ready_i) begin
                stall = 1'b1;
                snap  = snap_out();
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
                q.push_back(model(bus.Data_X_i, bus.Data_Y_i, bus.AddSubt_i));
                accepted++;
            end
        end
        @(negedge clk);
        if (stall && rst_n) begin
            chk("stall valid hold", 64'(bus.out_valid_o), 64'(1));
            chk_res("stall hold", snap);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y, input logic op);
        bus.in_valid_i = v;
        bus.Data_X_i   = x;
        bus.Data_Y_i   = y;
        bus.AddSubt_i  = op;
    endtask

    vec_t vecs[10];
    res_t ra;

    initial begin
        vecs[0] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40400000, 32'h3F800000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{32'h3F800000, 32'hC0400000, 1'b0, 32'hC0400000, 32'h3F800000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{32'h40000000, 32'h40000000, 1'b1, 32'h40000000, 32'h40000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{32'h40000000, 32'h40000000, 1'b0, 32'h40000000, 32'h40000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'hC0000000, 32'hC0000000, 1'b0, 32'hC0000000, 32'hC0000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'h80000000, 32'h00000000, 1'b0, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'h00000000, 32'h80000000, 1'b1, 32'h00000000, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{32'h3F800000, 32'h40400000, 1'b1, 32'h40400000, 32'h3F800000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{32'h7F800000, 32'hFF7FFFFF, 1'b0, 32'h7F800000, 32'hFF7FFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{32'h00000001, 32'h80000002, 1'b1, 32'h80000002, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset and idle
        rst_n = 1'b0;
        bus.out_ready_i = 1'b0;
        drive(1'b1, 32'hDEADBEEF, 32'h12345678, 1'b1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("reset out_valid", 64'(bus.out_valid_o), 64'(0));
        chk("reset in_ready", 64'(bus.in_ready_o), 64'(1));
        ra = '{32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        chk_res("reset", ra);
        @(negedge clk);

        // Directed vectors, one at a time, fixed 2-cycle latency
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].x, vecs[i].y, vecs[i].op);
            tick();
            drive(1'b0, 32'h0, 32'h0, 1'b0);
            chk($sformatf("vec%0d latency1 valid", i), 64'(bus.out_valid_o), 64'(0));
            tick();
            chk($sformatf("vec%0d latency2 valid", i), 64'(bus.out_valid_o), 64'(1));
            ra = '{vecs[i].e_dmp, vecs[i].e_dmp_small, vecs[i].e_gt, vecs[i].e_eq,
                   vecs[i].e_eff, vecs[i].e_sgn, vecs[i].e_zero};
            chk_res($sformatf("vec%0d", i), ra);
            chk($sformatf("vec%0d gt&eq exclusive", i), 64'(bus.gtXY_o & bus.eqXY_o), 64'(0));
            tick();
            chk($sformatf("vec%0d drained", i), 64'(bus.out_valid_o), 64'(0));
        end

        // Backpressure: 4 back-to-back sets, downstream stalled
        accepted = 0; popped = 0;
        bus.out_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 32'h41000000 + 32'(accepted), 32'hC0800000 + 32'(accepted), 1'b0);
            tick();
        end
        chk("bp accepted while stalled", 64'(accepted), 64'(2));
        #1;
        chk("bp in_ready low", 64'(bus.in_ready_o), 64'(0));
        ra = model(32'h41000000, 32'hC0800000, 1'b0);
        chk_res("bp first held", ra);
        @(negedge clk);
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 20 && popped < 4; c++) begin
            if (accepted < 4) drive(1'b1, 32'h41000000 + 32'(accepted), 32'hC0800000 + 32'(accepted), 1'b0);
            else              drive(1'b0, 32'h0, 32'h0, 1'b0);
            tick();
        end
        chk("bp results out", 64'(popped), 64'(4));
        chk("bp queue empty", 64'(q.size()), 64'(0));

        // Reset mid-stream with two items in flight
        drive(1'b1, 32'h3F000000, 32'h3E000000, 1'b0);
        tick();
        drive(1'b1, 32'h3E000000, 32'hBF000000, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst out_valid", 64'(bus.out_valid_o), 64'(0));
        chk("midrst DMP cleared", 64'(bus.DMP_o), 64'(0));
        popped = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.out_valid_o) popped++;
            tick();
        end
        chk("midrst nothing emerges", 64'(popped), 64'(0));

        // Random traffic against the scoreboard
        for (int c = 0; c < 400; c++) begin
            logic [W-1:0] rx, ry;
            int mode;
            rx = $urandom;
            ry = $urandom;
            mode = $urandom_range(0, 7);
            if (mode == 0)      ry = {ry[W-1], rx[W-2:0]};
            else if (mode == 1) begin rx = {rx[W-1], {(W-1){1'b0}}}; ry = {ry[W-1], {(W-1){1'b0}}}; end
            else if (mode == 2) ry = {ry[W-1], rx[W-2:8], ry[7:0]};
            drive($urandom_range(0, 9) < 7, rx, ry, 1'($urandom_range(0, 1)));
            bus.out_ready_i = ($urandom_range(0, 9) < 6);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) tick();
        chk("random drain empty", 64'(q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/oper_swap_cmp.md
Name: oper_swap_cmp

Overview:
- Front-end operand stage of the floating-point Add-Subt datapath.
- Registers X/Y operands and the operation bit, then compares magnitudes.
- Produces the gtXY/eqXY flags and swapped operands (larger magnitude first), plus effective-operation and result-sign bits.
- These outputs are the producer side of the comparison flags consumed by sign-of-result logic.
- Two-stage valid/ready pipeline feeding the exponent-difference and shift stages.

Parameters:
- W, 32, operand width (1 sign + exponent + mantissa); 32 single, 64 double.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid_i  in  1  operand set valid.
- in_ready_o  out  1  stage can accept operands.
- AddSubt_i  in  1  0 = add, 1 = subtract.
- Data_X_i  in  W  operand X.
- Data_Y_i  in  W  operand Y.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts.
- DMP_o  out  W  operand with larger (or equal) magnitude; X on tie.
- DmP_o  out  W  operand with smaller magnitude; Y on tie.
- gtXY_o  out  1  |X| > |Y|.
- eqXY_o  out  1  |X| == |Y|.
- eff_sub_o  out  1  effective subtraction: sgnX xor sgnY xor AddSubt.
- sgn_result_o  out  1  result sign.

Behaviour:
- Magnitude is bits [W-2:0] compared as an unsigned integer. Exponent-over-mantissa ordering makes this valid for normal, denormal, zero and inf operands. NaN is not handled here.
- Stage 1 (S1) is an input register: captures X, Y and AddSubt on in_valid_i & in_ready_o.
- Stage 2 (S2) is an output register: captures compare, swap and sign results computed from S1.
- Each stage has a valid bit v1/v2.
- Stall rules:
  - s2_adv = ~v2 | out_ready_i.
  - s1_adv = ~v1 | s2_adv.
  - in_ready_o = s1_adv, purely combinational.
- Latency is 2 cycles from accepted input to out_valid_o with no backpressure. Throughput is 1 per cycle.
- When out_valid_o is high and out_ready_i is low, all outputs hold stable. Data never changes under a stalled valid.
- Simultaneous events:
  - Full pipe, out_ready_i=1, in_valid_i=1: one result leaves, S1 moves to S2, new data enters S1 in the same cycle. No bubble, no loss.
  - S1 empty: S2 loads nothing and v2 clears after its handshake.
- Sign rule: sgn = (gt | (AddSubt ^ sgnY)) & (sgnX | ~(eq | gt)). This gives:
  - gt: sgnX.
  - lt: sgnY ^ AddSubt.
  - eq with eff_sub: +0.
  - eq with effective add: sgnX.
- gtXY_o and eqXY_o are never both 1.
- Reset (rst_n=0 at a clock edge):
  - v1, v2, out_valid_o = 0.
  - DMP_o, DmP_o = 0.
  - gtXY_o, eqXY_o, eff_sub_o, sgn_result_o = 0.
  - S1 data registers = 0.
  - in_ready_o = 1 from the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight data; no partial output appears.
- No internal counters overflow; the pipeline is strictly occupancy-limited to 2 entries.

Optional Feature:
- Macro: OPER_SWAP_ZERO_FLAG_EN.
- When defined: extra port zero_result_o (out, 1), registered in S2.
  - Asserted when eqXY & eff_sub, i.e. an exact cancellation.
  - Also asserted when both magnitudes are 0.
  - Reset value 0; holds under stall like the other outputs.
  - Lets the normaliser bypass leading-zero count.
- When undefined: port absent, no added logic. All other behaviour is identical.

Test Plan (W=32):
- Reset and idle: rst_n=0 for 2 cycles, then 1 → all outputs 0, in_ready_o=1, out_valid_o=0.
- X=0x40400000 (3.0), Y=0x3F800000 (1.0), AddSubt=1, single beat, out_ready_i=1 → 2 cycles later: out_valid_o=1, DMP_o=0x40400000, DmP_o=0x3F800000, gtXY=1, eqXY=0, eff_sub=1, sgn=0.
- X=0x3F800000, Y=0xC0400000 (-3.0), AddSubt=0 → DMP_o=0xC0400000, gtXY=0, eqXY=0, eff_sub=1, sgn=1.
- X=Y=0x40000000, AddSubt=1 → eqXY=1, DMP_o=X, DmP_o=Y, sgn=0; zero_result_o=1 when the macro is enabled.
- Backpressure: stream 4 operand sets back-to-back with out_ready_i=0 for cycles 3–6 → in_ready_o drops after 2 accepted. Outputs hold the first result unchanged. All 4 results emerge in order once ready returns, none lost or duplicated.
- Reset mid-stream: 2 items in flight, rst_n=0 for one cycle → out_valid_o=0 the next cycle, and neither item ever appears.
